// File: rtl/clkgate_ctrl.sv
// Clock-gate controller: sequences the enable of a downstream ICG through OFF/WAKE/ON/DRAIN.
// Optional OFF-cycle statistics counter is built only when CLKGATE_CTRL_STATS_EN is defined.
module clkgate_ctrl #(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_test_mode,
  output logic        o_e,
  output logic        o_te,
  output logic        o_ack,
  output logic [15:0] o_off_cnt
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_WAKE  = 2'd1,
    ST_ON    = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
  localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYCLES);

  state_t     r_state;
  logic [7:0] r_idle_cnt;
  logic [3:0] r_wake_cnt;
  logic       r_e;
  logic       r_ack;

  // Test enable bypasses the FSM and reset entirely.
  assign o_te  = i_test_mode;
  assign o_e   = r_e;
  assign o_ack = r_ack;

  // Gating FSM; the wake counter runs 0..WAKE_CYCLES so ACK lands WAKE_CYCLES+1 edges after the request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_OFF;
      r_idle_cnt <= 8'd0;
      r_wake_cnt <= 4'd0;
      r_e        <= 1'b0;
      r_ack      <= 1'b0;
    end else begin
      case (r_state)
        ST_OFF: begin
          r_idle_cnt <= 8'd0;
          r_wake_cnt <= 4'd0;
          r_ack      <= 1'b0;
          if (i_req) begin
            r_state <= ST_WAKE;
            r_e     <= 1'b1;
          end else begin
            r_state <= ST_OFF;
            r_e     <= 1'b0;
          end
        end
        ST_WAKE: begin
          r_e <= 1'b1;
          if (r_wake_cnt == WAKE_LAST) begin
            r_state    <= ST_ON;
            r_ack      <= 1'b1;
            r_idle_cnt <= 8'd0;
            r_wake_cnt <= 4'd0;
          end else begin
            r_state    <= ST_WAKE;
            r_ack      <= 1'b0;
            r_wake_cnt <= r_wake_cnt + 4'd1;
          end
        end
        ST_ON: begin
          r_e        <= 1'b1;
          r_wake_cnt <= 4'd0;
          // A request on the expiring cycle wins over the transition to DRAIN.
          if (i_req) begin
            r_state    <= ST_ON;
            r_ack      <= 1'b1;
            r_idle_cnt <= 8'd0;
          end else if (r_idle_cnt == IDLE_LAST) begin
            r_state    <= ST_DRAIN;
            r_ack      <= 1'b0;
            r_idle_cnt <= 8'd0;
          end else begin
            r_state    <= ST_ON;
            r_ack      <= 1'b1;
            r_idle_cnt <= r_idle_cnt + 8'd1;
          end
        end
        ST_DRAIN: begin
          r_idle_cnt <= 8'd0;
          r_wake_cnt <= 4'd0;
          if (i_req) begin
            r_state <= ST_ON;
            r_e     <= 1'b1;
            r_ack   <= 1'b1;
          end else begin
            r_state <= ST_OFF;
            r_e     <= 1'b0;
            r_ack   <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_OFF;
          r_idle_cnt <= 8'd0;
          r_wake_cnt <= 4'd0;
          r_e        <= 1'b0;
          r_ack      <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLKGATE_CTRL_STATS_EN
  logic [15:0] r_off_cnt;

  // Saturating count of edges spent in OFF.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_off_cnt <= 16'h0000;
    end else if ((r_state == ST_OFF) && (r_off_cnt != 16'hFFFF)) begin
      r_off_cnt <= r_off_cnt + 16'h0001;
    end else begin
      r_off_cnt <= r_off_cnt;
    end
  end

  assign o_off_cnt = r_off_cnt;
`else
  assign o_off_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_clkgate_ctrl.sv
// Directed bench for clkgate_ctrl: expected E/ACK/OFF_CNT pushed per driven cycle, popped after the edge.
module tb_clkgate_ctrl;

`ifdef CLKGATE_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        tm = 1'b0;
  logic        e, te, ack;
  logic [15:0] off_cnt;

  typedef struct {
    string       tag;
    logic        e;
    logic        ack;
    logic [15:0] off;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_off = 16'h0000;
  logic        prev_e = 1'b0;
  bit          tm_rand = 1'b0;

  clkgate_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_test_mode (tm),
    .o_e         (e),
    .o_te        (te),
    .o_ack       (ack),
    .o_off_cnt   (off_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Called just after a negedge: drive inputs, queue the post-edge expectation, compare, return at next negedge.
  task automatic step(input logic r, input logic exp_e, input logic exp_ack, input string tag);
    exp_t x;
    exp_t got;
    req = r;
    if (tm_rand) tm = 1'($urandom_range(0, 1));
    #1;
    chk({tag, "_te"}, {15'd0, te}, {15'd0, tm});
    if (STATS && !prev_e && exp_off != 16'hFFFF) exp_off = exp_off + 16'd1;
    x.tag = tag; x.e = exp_e; x.ack = exp_ack; x.off = exp_off;
    sb_q.push_back(x);
    prev_e = exp_e;
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk({got.tag, "_e"}, {15'd0, e}, {15'd0, got.e});
    chk({got.tag, "_ack"}, {15'd0, ack}, {15'd0, got.ack});
    chk({got.tag, "_off"}, off_cnt, got.off);
    @(negedge clk);
  endtask

  // Assert reset at a negedge (outputs must drop before any edge), hold n cycles, release at a negedge.
  task automatic do_reset(input int n, input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst_e"}, {15'd0, e}, 16'd0);
    chk({tag, "_rst_ack"}, {15'd0, ack}, 16'd0);
    chk({tag, "_rst_off"}, off_cnt, 16'd0);
    tm = 1'b1;
    #1;
    chk({tag, "_rst_te1"}, {15'd0, te}, 16'd1);
    tm = 1'b0;
    #1;
    chk({tag, "_rst_te0"}, {15'd0, te}, 16'd0);
    repeat (n) @(negedge clk);
    chk({tag, "_rst_hold_e"}, {15'd0, e}, 16'd0);
    exp_off = 16'h0000;
    prev_e  = 1'b0;
    rst_n   = 1'b1;
  endtask

  // Wake from OFF with req held at r for the WAKE cycles; ends on the edge that raises ACK.
  task automatic wake_seq(input logic r, input string tag);
    step(1'b1, 1'b1, 1'b0, {tag, "_wake0"});
    step(r,    1'b1, 1'b0, {tag, "_wake1"});
    step(r,    1'b1, 1'b0, {tag, "_wake2"});
    step(r,    1'b1, 1'b1, {tag, "_ack"});
  endtask

  // 15 idle ON cycles, then the 16th idle cycle enters DRAIN.
  task automatic idle_to_drain(input string tag);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b1, {tag, "_on_idle"});
    step(1'b0, 1'b1, 1'b0, {tag, "_drain"});
  endtask

  initial begin
    @(negedge clk);
    do_reset(3, "por");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, "off_idle");

    // Single-cycle REQ pulse through the full lifecycle.
    wake_seq(1'b0, "pulse");
    idle_to_drain("pulse");
    step(1'b0, 1'b0, 1'b0, "pulse_off");

    // REQ on the expiring idle cycle keeps ON and restarts the idle count.
    wake_seq(1'b1, "prec");
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b1, "prec_idle");
    step(1'b1, 1'b1, 1'b1, "prec_expire");
    idle_to_drain("prec_restart");

    // REQ exactly in DRAIN returns straight to ON without WAKE.
    step(1'b1, 1'b1, 1'b1, "drain_rescue");
    idle_to_drain("rescue");
    step(1'b0, 1'b0, 1'b0, "rescue_off");

    // Reset pulse mid-WAKE, REQ held: full WAKE repeats.
    step(1'b1, 1'b1, 1'b0, "mid_wake0");
    step(1'b1, 1'b1, 1'b0, "mid_wake1");
    do_reset(1, "mid");
    wake_seq(1'b1, "rewake");
    idle_to_drain("rewake");
    step(1'b0, 1'b0, 1'b0, "rewake_off");

    // Same lifecycle with TEST_MODE toggling randomly: E/ACK sequence unchanged.
    tm_rand = 1'b1;
    step(1'b0, 1'b0, 1'b0, "tm_off");
    wake_seq(1'b0, "tm");
    idle_to_drain("tm");
    step(1'b1, 1'b1, 1'b1, "tm_rescue");
    idle_to_drain("tm2");
    step(1'b0, 1'b0, 1'b0, "tm_off2");
    tm_rand = 1'b0;

    n_cmp++;
    assert (sb_q.size() == 0) else begin
      n_err++;
      $error("FAIL sb_drain: observed %0d expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clkgate_ctrl.md
CLKGATE_CTRL -- requirements
Module: clkgate_ctrl

Interface
REQ-001: Parameter IDLE_CYCLES, default 16: consecutive REQ-low cycles in ON before gating starts; legal range 1..255.
REQ-002: Parameter WAKE_CYCLES, default 2: cycles between E assertion and ACK assertion; legal range 1..15.
REQ-003: CLK  input  1  free-running clock; all state updates on its rising edge.
REQ-004: RN  input  1  reset; asynchronous, active-low.
REQ-005: REQ  input  1  client activity request; synchronous to CLK.
REQ-006: TEST_MODE  input  1  scan/test enable request.
REQ-007: E  output  1  functional enable to downstream integrated clock gate.
REQ-008: TE  output  1  test enable to downstream integrated clock gate.
REQ-009: ACK  output  1  gated clock guaranteed running; client may operate.
REQ-010: OFF_CNT  output  16  count of cycles spent in OFF (see Configuration).

Function
REQ-011: Controller SHALL implement four states: OFF, WAKE, ON, DRAIN; state, E, ACK and all counters registered.
REQ-012: OFF: E=0, ACK=0; REQ=1 -> WAKE next edge, E=1 from that edge.
REQ-013: WAKE: E=1, ACK=0; wake counter counts WAKE_CYCLES edges, then -> ON with ACK=1 from that edge; REQ ignored in WAKE.
REQ-014: With WAKE_CYCLES=2, ACK SHALL rise exactly 3 edges after the edge sampling REQ=1 in OFF.
REQ-015: ON: E=1, ACK=1; REQ=1 clears idle counter to 0; REQ=0 increments idle counter.
REQ-016: ON with REQ=0 and idle counter = IDLE_CYCLES-1 -> DRAIN next edge, ACK=0 from that edge; E stays 1.
REQ-017: Simultaneous REQ=1 on the expiring cycle SHALL take precedence: counter clears, state stays ON.
REQ-018: DRAIN lasts exactly one cycle with E=1, ACK=0; REQ=1 in DRAIN -> ON (ACK=1 next edge, no WAKE); REQ=0 -> OFF (E=0 next edge).
REQ-019: Idle counter SHALL clear on every entry into ON and SHALL never exceed IDLE_CYCLES-1.
REQ-020: E SHALL never go 0 while ACK=1; ACK SHALL never be 1 unless E has been 1 for at least WAKE_CYCLES edges.
REQ-021: TE SHALL equal TEST_MODE combinationally, independent of RN and state.
REQ-022: TEST_MODE SHALL NOT alter FSM state transitions.

Reset
REQ-023: RN=0 SHALL asynchronously force state OFF, E=0, ACK=0, idle counter 0, wake counter 0, OFF_CNT 0.
REQ-024: Reset asserted mid-WAKE, ON or DRAIN SHALL drop E and ACK immediately, without waiting for a clock edge.
REQ-025: After RN deassertion, first edge SHALL evaluate from OFF; REQ=1 at that edge -> WAKE.

Configuration
REQ-026: Macro CLKGATE_CTRL_STATS_EN defined: OFF_CNT SHALL increment by 1 on every edge with state OFF, saturate at 16'hFFFF, and hold elsewhere.
REQ-027: Macro CLKGATE_CTRL_STATS_EN undefined: OFF_CNT SHALL be constant 16'h0000 and no counter logic SHALL be present.

Verification
REQ-028: RN low 3 cycles, REQ=0, release -> E=0, ACK=0, OFF_CNT increments 1/cycle (stats on) or stays 0 (stats off).
REQ-029: Defaults, REQ pulse 1 cycle in OFF -> E=1 next edge, ACK=1 3 edges after sample, DRAIN entered 16 REQ-low ON cycles later, E=0 one edge after DRAIN.
REQ-030: In ON, REQ=0 for 15 cycles then REQ=1 on 16th -> remains ON, ACK=1, idle counter 0.
REQ-031: REQ=1 exactly during DRAIN -> ACK=1 next edge, E never drops, no WAKE state visited.
REQ-032: RN asserted 1 cycle mid-WAKE -> E=0, ACK=0 asynchronously; REQ held 1 -> full WAKE of 2 cycles repeated.
REQ-033: TEST_MODE toggled with RN=0 and in each state -> TE follows same-cycle, E/ACK/state sequence identical to TEST_MODE=0 run.
